vga_mem_arbiter: RTL and testbench

//  Single-port video memory scheduler between the VGA pixel-fetch path (display) and the CPU/draw port.

---
 rtl/vga_mem_pkg.sv | 15 +
 rtl/vga_rd_tag_pipe.sv | 43 ++++
 rtl/vga_mem_arbiter.sv | 109 ++++++++++
 tb/tb_vga_mem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mem_pkg.sv
// Shared types and defaults for the video memory arbiter: owner-tag encoding and bus widths.
// No logic; imported by the arbiter top and its read-tag pipeline.
package vga_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_DISP = 2'b01,
    OWN_CPU  = 2'b10
  } owner_t;

  localparam int ADDR_W_DEF       = 16;
  localparam int DATA_W_DEF       = 16;
  localparam int CPU_MAX_WAIT_DEF = 32;

endpackage

// File: rtl/vga_rd_tag_pipe.sv
// Two-stage owner-tag shift register aligned with RAM read latency; steers mem_rdata to the tagged owner.
// rvalid 2 cycles after the tag enters; no backpressure, rdata holds between valid beats.
module vga_rd_tag_pipe
  import vga_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              clear,
  input  owner_t            tag_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata
);

  owner_t            tag_s1;
  owner_t            tag_s2;
  logic [DATA_W-1:0] disp_hold;
  logic [DATA_W-1:0] cpu_hold;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      tag_s1    <= OWN_NONE;
      tag_s2    <= OWN_NONE;
      disp_hold <= '0;
      cpu_hold  <= '0;
    end else begin
      tag_s1 <= tag_in;
      tag_s2 <= tag_s1;
      if (tag_s2 == OWN_DISP) disp_hold <= mem_rdata;
      if (tag_s2 == OWN_CPU)  cpu_hold  <= mem_rdata;
    end
  end

  // RAM data arrives in the same cycle the tag reaches stage 2, so pass it through and latch it for holding.
  assign disp_rvalid = (tag_s2 == OWN_DISP);
  assign cpu_rvalid  = (tag_s2 == OWN_CPU);
  assign disp_rdata  = disp_rvalid ? mem_rdata : disp_hold;
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : cpu_hold;

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port frame-buffer arbiter (display vs CPU), one grant per clock, read latency 2 from grant.
// Loser simply holds req; optional CPU starvation guard enabled by VGA_ARB_STARVE_GUARD_EN.
module vga_mem_arbiter
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CPU_MAX_WAIT = CPU_MAX_WAIT_DEF
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              in_blank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_grant,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_grant,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic   starve;
  logic   cpu_first;
  owner_t tag_in;

`ifdef VGA_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wait_cnt <= '0;
    end else if (!cpu_req || cpu_grant) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign starve = (wait_cnt == WAIT_MAX);
`else
  assign starve = (CPU_MAX_WAIT < 0);
`endif

  always_comb begin
    cpu_first  = in_blank | starve;
    disp_grant = 1'b0;
    cpu_grant  = 1'b0;
    if (!clear) begin
      if (cpu_first) begin
        cpu_grant  = cpu_req;
        disp_grant = disp_req & ~cpu_req;
      end else begin
        disp_grant = disp_req;
        cpu_grant  = cpu_req & ~disp_req;
      end
    end
    // Writes carry no owner so they never produce rvalid.
    tag_in = OWN_NONE;
    if (disp_grant)
      tag_in = OWN_DISP;
    else if (cpu_grant && !cpu_we)
      tag_in = OWN_CPU;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= disp_grant | cpu_grant;
      mem_we <= cpu_grant & cpu_we;
      if (disp_grant) begin
        mem_addr <= disp_addr;
      end else if (cpu_grant) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end
    end
  end

  vga_rd_tag_pipe #(
    .DATA_W (DATA_W)
  ) u_tag_pipe (
    .clock       (clock),
    .clear       (clear),
    .tag_in      (tag_in),
    .mem_rdata   (mem_rdata),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata)
  );

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter with a behavioural synchronous RAM (initial contents 0x1000 + address).
module tb_vga_mem_arbiter;

  logic        clock = 1'b0;
  logic        clear;
  logic        in_blank;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic        disp_grant;
  logic        disp_rvalid;
  logic [15:0] disp_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_grant;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] ram [0:65535];

  int checks   = 0;
  int failures = 0;

  vga_mem_arbiter #(
    .ADDR_W       (16),
    .DATA_W       (16),
    .CPU_MAX_WAIT (4)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .in_blank    (in_blank),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_grant  (disp_grant),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_grant   (cpu_grant),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled mid-cycle.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    #3;
  endtask

  task automatic idle(input int n);
    disp_req = 1'b0;
    cpu_req  = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 16'h1000 + 16'(i);
    mem_rdata = 16'h0;
    clear     = 1'b1;
    in_blank  = 1'b0;
    disp_req  = 1'b0;
    disp_addr = 16'h0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0;
    cpu_wdata = 16'h0;

    // Reset state
    cyc(); cyc(); smp();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_disp_rvalid", disp_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    cyc();
    clear = 1'b0;
    cyc();

    // Display priority during active video
    in_blank = 1'b0;
    disp_req = 1'b1; disp_addr = 16'h0010;
    cpu_req  = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    smp();
    chk("act_c0_disp_grant", disp_grant, 1);
    chk("act_c0_cpu_grant", cpu_grant, 0);
    cyc(); disp_req = 1'b0; smp();
    chk("act_c1_cpu_grant", cpu_grant, 1);
    chk("act_c1_mem_addr", mem_addr, 16'h0010);
    chk("act_c1_mem_en", mem_en, 1);
    cyc(); cpu_req = 1'b0; smp();
    chk("act_c2_mem_addr", mem_addr, 16'h0020);
    chk("act_c2_disp_rvalid", disp_rvalid, 1);
    chk("act_c2_disp_rdata", disp_rdata, 16'h1010);
    chk("act_c2_cpu_rvalid", cpu_rvalid, 0);
    cyc(); smp();
    chk("act_c3_cpu_rvalid", cpu_rvalid, 1);
    chk("act_c3_cpu_rdata", cpu_rdata, 16'h1020);
    chk("act_c3_disp_rvalid", disp_rvalid, 0);
    chk("act_c3_disp_rdata_hold", disp_rdata, 16'h1010);
    chk("act_c3_mem_en", mem_en, 0);
    idle(3);

    // CPU priority during blanking
    in_blank = 1'b1;
    disp_req = 1'b1; disp_addr = 16'h0010;
    cpu_req  = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    smp();
    chk("blk_c0_cpu_grant", cpu_grant, 1);
    chk("blk_c0_disp_grant", disp_grant, 0);
    cyc(); cpu_req = 1'b0; smp();
    chk("blk_c1_disp_grant", disp_grant, 1);
    chk("blk_c1_mem_addr", mem_addr, 16'h0020);
    idle(4);

    // CPU write then read-back of the same address
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'hBEEF;
    smp();
    chk("wr_grant", cpu_grant, 1);
    cyc(); cpu_we = 1'b0; smp();
    chk("rd_grant", cpu_grant, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
    chk("wr_mem_addr", mem_addr, 16'h0100);
    cyc(); cpu_req = 1'b0; smp();
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("wr_no_cpu_rvalid", cpu_rvalid, 0);
    cyc(); smp();
    chk("rd_cpu_rvalid", cpu_rvalid, 1);
    chk("rd_cpu_rdata", cpu_rdata, 16'hBEEF);
    chk("rd_no_disp_rvalid", disp_rvalid, 0);
    cyc(); smp();
    chk("rd_cpu_rvalid_once", cpu_rvalid, 0);
    chk("rd_cpu_rdata_hold", cpu_rdata, 16'hBEEF);
    idle(2);

    // Display streaming 0x0000..0x0007, one read per cycle
    in_blank = 1'b0;
    for (int k = 0; k < 10; k++) begin
      disp_req  = (k < 8);
      disp_addr = 16'(k);
      smp();
      chk($sformatf("strm_grant_%0d", k), disp_grant, (k < 8) ? 1 : 0);
      chk($sformatf("strm_rvalid_%0d", k), disp_rvalid, (k >= 2) ? 1 : 0);
      if (k >= 2) chk($sformatf("strm_rdata_%0d", k), disp_rdata, 16'h1000 + 16'(k - 2));
      if (k >= 1 && k <= 8) chk($sformatf("strm_maddr_%0d", k), mem_addr, 16'(k - 1));
      cyc();
    end
    idle(2);

    // Clear one cycle after a display read grant: that read must vanish
    disp_req = 1'b1; disp_addr = 16'h0005;
    smp();
    chk("clr_grant", disp_grant, 1);
    cyc(); disp_req = 1'b0; clear = 1'b1; smp();
    chk("clr_mem_en", mem_en, 0);
    chk("clr_mem_addr", mem_addr, 0);
    chk("clr_disp_rdata", disp_rdata, 0);
    cyc(); clear = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk($sformatf("clr_no_rvalid_%0d", k), disp_rvalid, 0);
      chk($sformatf("clr_rdata_zero_%0d", k), disp_rdata, 0);
      cyc();
    end

    // Display and CPU both held during active video
    in_blank = 1'b0;
    cpu_we = 1'b0; cpu_addr = 16'h0030;
    for (int c = 0; c < 10; c++) begin
      disp_req  = 1'b1;
      disp_addr = 16'h0040 + 16'(c);
`ifdef VGA_ARB_STARVE_GUARD_EN
      cpu_req = (c <= 4);
      smp();
      chk($sformatf("starve_cpu_grant_%0d", c), cpu_grant, (c == 4) ? 1 : 0);
      chk($sformatf("starve_disp_grant_%0d", c), disp_grant, (c == 4) ? 0 : 1);
`else
      cpu_req = 1'b1;
      smp();
      chk($sformatf("starve_cpu_grant_%0d", c), cpu_grant, 0);
      chk($sformatf("starve_disp_grant_%0d", c), disp_grant, 1);
`endif
      cyc();
    end
`ifndef VGA_ARB_STARVE_GUARD_EN
    disp_req = 1'b0;
    smp();
    chk("starve_release_cpu_grant", cpu_grant, 1);
    cyc();
`endif
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
